// File: rtl/ex_stage_pkg.sv
// Shared widths, bus payload layouts, decode constants and divider states for the EX stage.
package ex_stage_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned STALL_WD     = 6;
  localparam int unsigned ALU_OP_WD    = 12;
  localparam int unsigned ID_TO_EX_WD  = 159;
  localparam int unsigned EX_TO_MEM_WD = 76;
  localparam int unsigned EX_TO_ID_WD  = 38;
  localparam int unsigned STALL_EX     = 2;
  localparam int unsigned STALL_MEM    = 3;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // One-hot ALU op codes, MSB first
  localparam logic [ALU_OP_WD-1:0] OP_ADD  = 12'h800;
  localparam logic [ALU_OP_WD-1:0] OP_SUB  = 12'h400;
  localparam logic [ALU_OP_WD-1:0] OP_SLT  = 12'h200;
  localparam logic [ALU_OP_WD-1:0] OP_SLTU = 12'h100;
  localparam logic [ALU_OP_WD-1:0] OP_AND  = 12'h080;
  localparam logic [ALU_OP_WD-1:0] OP_NOR  = 12'h040;
  localparam logic [ALU_OP_WD-1:0] OP_OR   = 12'h020;
  localparam logic [ALU_OP_WD-1:0] OP_XOR  = 12'h010;
  localparam logic [ALU_OP_WD-1:0] OP_SLL  = 12'h008;
  localparam logic [ALU_OP_WD-1:0] OP_SRL  = 12'h004;
  localparam logic [ALU_OP_WD-1:0] OP_SRA  = 12'h002;
  localparam logic [ALU_OP_WD-1:0] OP_LUI  = 12'h001;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      inst;
    logic [ALU_OP_WD-1:0] alu_op;
    logic [2:0]           sel_src1;
    logic [3:0]           sel_src2;
    logic                 ram_en;
    logic [3:0]           ram_wen;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic                 sel_rf_res;
    logic [XLEN-1:0]      rdata1;
    logic [XLEN-1:0]      rdata2;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            ram_en;
    logic [3:0]      ram_wen;
    logic            sel_rf_res;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] result;
  } ex_mem_t;

  typedef struct packed {
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] result;
  } ex_id_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID-to-EX input bus plus every EX output toward MEM, ID and the data SRAM.
interface ex_stage_if;
  import ex_stage_pkg::*;

  id_ex_t          id_to_ex_bus;
  ex_mem_t         ex_to_mem_bus;
  ex_id_t          ex_to_id_bus;
  logic            is_lw;
  logic            stallreq_for_ex;
  logic            data_sram_en;
  logic [3:0]      data_sram_wen;
  logic [XLEN-1:0] data_sram_addr;
  logic [XLEN-1:0] data_sram_wdata;

  modport master (
    output id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_bus, is_lw, stallreq_for_ex,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_bus, is_lw, stallreq_for_ex,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage_div_iter.sv
// 32-step restoring divider on operand magnitudes; signs and divide-by-zero fixed up at the output.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic            i_ack,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  div_state_e      r_state;
  div_state_e      w_state_next;
  logic [4:0]      r_count;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_b_zero;

  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_borrow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= DIV_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      DIV_IDLE: if (i_start)              w_state_next = DIV_BUSY;
      DIV_BUSY: if (r_count == 5'd31)     w_state_next = DIV_DONE;
      DIV_DONE: if (i_ack)                w_state_next = DIV_IDLE;
      default:                            w_state_next = DIV_IDLE;
    endcase
  end

  // Quotient bits are shifted into r_quo as the dividend bits shift out of it
  assign w_shift  = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, r_div};
  assign w_borrow = w_diff[XLEN+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
    end else begin
      unique case (r_state)
        DIV_IDLE: if (i_start) begin
          r_count  <= '0;
          r_rem    <= '0;
          r_quo    <= abs32(i_a, i_signed);
          r_div    <= abs32(i_b, i_signed);
          r_neg_q  <= i_signed & (i_a[XLEN-1] ^ i_b[XLEN-1]);
          r_neg_r  <= i_signed & i_a[XLEN-1];
          r_b_zero <= (i_b == '0);
        end
        DIV_BUSY: begin
          r_rem   <= w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
          r_quo   <= {r_quo[XLEN-2:0], ~w_borrow};
          r_count <= r_count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state == DIV_BUSY);
  assign o_done      = (r_state == DIV_DONE);
  // A zero divisor leaves the dividend as remainder; only the quotient needs forcing
  assign o_quotient  = r_b_zero ? '1 : (r_neg_q ? XLEN'(-r_quo) : r_quo);
  assign o_remainder = r_neg_r ? XLEN'(-r_rem) : r_rem;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, inline ALU, HI/LO with multiplier and iterative divider.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_WD-1:0] stall,
  ex_stage_if.slave           bus
);

  id_ex_t          r_id;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic            w_special;
  logic [5:0]      w_funct;
  logic            w_is_mult, w_is_div, w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
  logic            w_is_mf;
  logic [XLEN-1:0] w_src1, w_src2, w_alu_res, w_result;
  logic [4:0]      w_shamt;
  logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
  logic            w_div_busy, w_div_done, w_stallreq;
  logic [XLEN-1:0] w_div_q, w_div_r;
  logic            w_leave;
  logic            w_unused_ok;

  // Bubble when EX holds but MEM advances; otherwise load unless EX is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     r_id <= '0;
    else if (stall[STALL_EX] && !stall[STALL_MEM]) r_id <= '0;
    else if (!stall[STALL_EX])                    r_id <= bus.id_to_ex_bus;
  end

  assign w_special = (r_id.inst[31:26] == 6'd0);
  assign w_funct   = r_id.inst[5:0];
  assign w_is_mult = w_special && (w_funct == FUNCT_MULT || w_funct == FUNCT_MULTU);
  assign w_is_div  = w_special && (w_funct == FUNCT_DIV  || w_funct == FUNCT_DIVU);
  assign w_is_mfhi = w_special && (w_funct == FUNCT_MFHI);
  assign w_is_mflo = w_special && (w_funct == FUNCT_MFLO);
  assign w_is_mthi = w_special && (w_funct == FUNCT_MTHI);
  assign w_is_mtlo = w_special && (w_funct == FUNCT_MTLO);
  assign w_is_mf   = w_is_mfhi | w_is_mflo;
  assign w_unused_ok = ^r_id.inst[25:16];

  always_comb begin
    w_src1 = r_id.rdata1;
    if      (r_id.sel_src1[0]) w_src1 = r_id.rdata1;
    else if (r_id.sel_src1[1]) w_src1 = r_id.pc;
    else if (r_id.sel_src1[2]) w_src1 = {27'd0, r_id.inst[10:6]};
  end

  always_comb begin
    w_src2 = '0;
    if      (r_id.sel_src2[0]) w_src2 = r_id.rdata2;
    else if (r_id.sel_src2[1]) w_src2 = {{16{r_id.inst[15]}}, r_id.inst[15:0]};
    else if (r_id.sel_src2[2]) w_src2 = 32'd8;
    else if (r_id.sel_src2[3]) w_src2 = {16'd0, r_id.inst[15:0]};
  end

  assign w_shamt = w_src1[4:0];

  always_comb begin
    w_alu_res = '0;
    unique case (r_id.alu_op)
      OP_ADD:  w_alu_res = w_src1 + w_src2;
      OP_SUB:  w_alu_res = w_src1 - w_src2;
      OP_SLT:  w_alu_res = {31'd0, $signed(w_src1) < $signed(w_src2)};
      OP_SLTU: w_alu_res = {31'd0, w_src1 < w_src2};
      OP_AND:  w_alu_res = w_src1 & w_src2;
      OP_NOR:  w_alu_res = ~(w_src1 | w_src2);
      OP_OR:   w_alu_res = w_src1 | w_src2;
      OP_XOR:  w_alu_res = w_src1 ^ w_src2;
      OP_SLL:  w_alu_res = w_src2 << w_shamt;
      OP_SRL:  w_alu_res = w_src2 >> w_shamt;
      OP_SRA:  w_alu_res = XLEN'($signed(w_src2) >>> w_shamt);
      OP_LUI:  w_alu_res = {w_src2[15:0], 16'd0};
      default: w_alu_res = '0;
    endcase
  end

  // Operands are extended to 64 bits so one multiplier serves signed and unsigned
  assign w_mul_a = {{XLEN{(w_funct == FUNCT_MULT) & r_id.rdata1[XLEN-1]}}, r_id.rdata1};
  assign w_mul_b = {{XLEN{(w_funct == FUNCT_MULT) & r_id.rdata2[XLEN-1]}}, r_id.rdata2};
  assign w_prod  = w_mul_a * w_mul_b;

  div_iter u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_is_div),
    .i_signed    (w_funct == FUNCT_DIV),
    .i_ack       (!stall[STALL_MEM]),
    .i_a         (r_id.rdata1),
    .i_b         (r_id.rdata2),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  assign w_stallreq = w_div_busy | (w_is_div & ~w_div_done);
  assign w_leave    = !stall[STALL_MEM];

  // HI/LO change only on the edge where the owning instruction leaves EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_leave) begin
      if (w_is_mult) begin
        r_hi <= w_prod[2*XLEN-1:XLEN];
        r_lo <= w_prod[XLEN-1:0];
      end else if (w_is_div && w_div_done) begin
        r_hi <= w_div_r;
        r_lo <= w_div_q;
      end else if (w_is_mthi) begin
        r_hi <= r_id.rdata1;
      end else if (w_is_mtlo) begin
        r_lo <= r_id.rdata1;
      end
    end
  end

  assign w_result = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : w_alu_res);

  always_comb begin
    bus.ex_to_mem_bus.pc         = r_id.pc;
    bus.ex_to_mem_bus.ram_en     = r_id.ram_en;
    bus.ex_to_mem_bus.ram_wen    = r_id.ram_wen;
    bus.ex_to_mem_bus.sel_rf_res = r_id.sel_rf_res;
    bus.ex_to_mem_bus.rf_we      = r_id.rf_we | w_is_mf;
    bus.ex_to_mem_bus.rf_waddr   = w_is_mf ? r_id.inst[15:11] : r_id.rf_waddr;
    bus.ex_to_mem_bus.result     = w_result;
  end

  always_comb begin
    bus.ex_to_id_bus.rf_we    = r_id.rf_we | w_is_mf;
    bus.ex_to_id_bus.rf_waddr = w_is_mf ? r_id.inst[15:11] : r_id.rf_waddr;
    bus.ex_to_id_bus.result   = w_result;
  end

  assign bus.is_lw           = r_id.sel_rf_res;
  assign bus.stallreq_for_ex = w_stallreq;
  assign bus.data_sram_en    = r_id.ram_en;
  assign bus.data_sram_wen   = r_id.ram_wen;
  assign bus.data_sram_addr  = w_result;
  assign bus.data_sram_wdata = r_id.rdata2;

endmodule
